mem_wb_reg: RTL

- Pipeline register between the MEM stage and the WB stage.
- Captures the MEM-stage write-back bundle: GPR write enable/address/data, plus optional HI/LO.
- Presents the bundle one cycle later. The GPR fields drive the register file write port (we/waddr/wdata).
- Honours the global stall vector and flush from the control unit. Keeps a retired-instruction counter for debug and performance visibility.

---
 rtl/mem_wb_reg.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_reg
//  Description : MEM -> WB pipeline register. It captures the GPR write-back
//                bundle and presents it one cycle later to the register-file
//                write port. It honours the global stall vector and the flush
//                input, and it counts instructions that enter WB.
//                Optional HI/LO write-back fields exist when the macro
//                MEM_WB_HILO_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,          // synchronous, active-low
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
`ifdef MEM_WB_HILO_EN
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
`endif
    output logic              wb_valid,
    output logic              wb_wreg,
    output logic [ADDR_W-1:0] wb_wd,
    output logic [DATA_W-1:0] wb_wdata,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int               C_STALL_MEM = 4;
    localparam int               C_STALL_WB  = 5;
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    // MEM stalled while WB runs: WB must see a bubble, otherwise the write
    // held in this register would be applied to the register file twice.
    logic w_bubble;
    // MEM advancing: take a new bundle. The illegal pattern (WB stalled,
    // MEM running) also lands here.
    logic w_capture;
    // Lower stall bits belong to earlier stages and do not affect this one.
    logic w_unused_stall;

    assign w_bubble       = stall[C_STALL_MEM] & ~stall[C_STALL_WB];
    assign w_capture      = ~stall[C_STALL_MEM];
    assign w_unused_stall = ^stall[3:0];

    // GPR write-back bundle: reset > flush > bubble > capture > hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_wreg  <= 1'b0;
            wb_wd    <= '0;
            wb_wdata <= '0;
        end else if (flush || w_bubble) begin
            wb_valid <= 1'b0;
            wb_wreg  <= 1'b0;
            wb_wd    <= '0;
            wb_wdata <= '0;
        end else if (w_capture) begin
            wb_valid <= mem_valid;
            wb_wreg  <= mem_wreg & mem_valid;
            wb_wd    <= mem_wd;     // GPR 0 is passed through unfiltered
            wb_wdata <= mem_wdata;
        end
    end

    // Retired-instruction counter: counts real instructions entering WB, wraps
    always_ff @(posedge clk) begin
        if (!rst) begin
            retire_cnt <= '0;
        end else if (!flush && w_capture && mem_valid) begin
            retire_cnt <= retire_cnt + C_CNT_ONE;
        end
    end

`ifdef MEM_WB_HILO_EN
    // HI/LO write-back fields use the same priority as the GPR fields
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_whilo <= 1'b0;
            wb_hi    <= '0;
            wb_lo    <= '0;
        end else if (flush || w_bubble) begin
            wb_whilo <= 1'b0;
            wb_hi    <= '0;
            wb_lo    <= '0;
        end else if (w_capture) begin
            wb_whilo <= mem_whilo & mem_valid;
            wb_hi    <= mem_hi;
            wb_lo    <= mem_lo;
        end
    end
`endif

    // The illegal stall pattern is handled as a capture but should never occur
    a_legal_stall: assert property (@(posedge clk) disable iff (!rst)
        !(stall[C_STALL_WB] && !stall[C_STALL_MEM]));

endmodule
`default_nettype wire
